// File: rtl/vectored_intc.sv
// Vectored interrupt controller: edge-latched requests, fixed priority, vector/EPC generation.
// Define VECTORED_INTC_NEST_EN to allow one level of preemption by a higher-priority channel.
module vectored_intc #(
  parameter int          NCHAN      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h000001F0,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCHAN-1:0] irq,
  input  logic             mask_we,
  input  logic [NCHAN-1:0] mask_in,
  input  logic [31:0]      pc_next,
  input  logic             ret,
  output logic             int_ack,
  output logic [31:0]      vec_addr,
  output logic [31:0]      epc,
  output logic [3:0]       irq_id,
  output logic [NCHAN-1:0] pending,
  output logic             in_service
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SERVICE  = 2'd1;
`ifdef VECTORED_INTC_NEST_EN
  localparam logic [1:0] SERVICE2 = 2'd2;
`endif

  logic [NCHAN-1:0] irq_p0;
  logic             armed_p0;
  logic [NCHAN-1:0] pend_q;
  logic [NCHAN-1:0] mask_q;
  logic [1:0]       state_q;
  logic [31:0]      epc_q;
  logic [3:0]       id_q;

  logic [NCHAN-1:0] eligible;
  logic [NCHAN-1:0] edge_set;
  logic [NCHAN-1:0] take_clr;
  logic [4:0]       sel;
  logic             take;
  logic [3:0]       take_id;
  int               lim;

  // Lowest eligible index below lim; result is {found, id}.
  function automatic logic [4:0] pick(input logic [NCHAN-1:0] el, input int lim_i);
    logic [4:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (el[i] && (i < lim_i)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  always_comb begin
    eligible = pend_q & mask_q;
    lim      = 0;
    if (state_q == IDLE) lim = NCHAN;
`ifdef VECTORED_INTC_NEST_EN
    else if (state_q == SERVICE) lim = int'(id_q);
`endif
    sel      = pick(eligible, lim);
    // A take never coincides with ret, so the earliest take after a return is the next cycle.
    take     = sel[4] & ~ret & ~reset;
    take_id  = sel[3:0];
    edge_set = armed_p0 ? (irq & ~irq_p0) : '0;
    take_clr = take ? (NCHAN'(1) << take_id) : '0;
  end

  assign int_ack    = take;
  assign vec_addr   = take ? (VEC_BASE + 32'(take_id) * 32'(VEC_STRIDE)) : 32'd0;
  assign epc        = epc_q;
  assign irq_id     = id_q;
  assign pending    = pend_q;
  assign in_service = (state_q != IDLE);

`ifdef VECTORED_INTC_NEST_EN
  logic [31:0] stk_epc;
  logic [3:0]  stk_id;

  always_ff @(posedge clk) begin
    if (take && state_q == SERVICE) begin
      stk_epc <= epc_q;
      stk_id  <= id_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_p0   <= '0;
      armed_p0 <= 1'b0;
      pend_q   <= '0;
      mask_q   <= '1;
      state_q  <= IDLE;
      epc_q    <= '0;
      id_q     <= '0;
    end else begin
      irq_p0   <= irq;
      armed_p0 <= 1'b1;
      // A new edge on the channel being taken survives the clear.
      pend_q   <= (pend_q & ~take_clr) | edge_set;
      if (mask_we) mask_q <= mask_in;
      if (take) begin
        epc_q <= pc_next;
        id_q  <= take_id;
`ifdef VECTORED_INTC_NEST_EN
        if (state_q == SERVICE) state_q <= SERVICE2;
        else                    state_q <= SERVICE;
`else
        state_q <= SERVICE;
`endif
      end else if (ret) begin
        if (state_q == SERVICE) state_q <= IDLE;
`ifdef VECTORED_INTC_NEST_EN
        else if (state_q == SERVICE2) begin
          state_q <= SERVICE;
          epc_q   <= stk_epc;
          id_q    <= stk_id;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_vectored_intc.sv
// Self-checking bench for vectored_intc: directed scenarios plus random traffic vs a behavioural model.
module tb_vectored_intc;

`ifdef VECTORED_INTC_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_in;
  logic [31:0] pc_next;
  logic        ret;
  logic        int_ack;
  logic [31:0] vec_addr;
  logic [31:0] epc;
  logic [3:0]  irq_id;
  logic [3:0]  pending;
  logic        in_service;

  int errors = 0;
  int checks = 0;

  // Behavioural model: pending/mask bit sets, nesting depth, and a stack of saved contexts.
  logic [3:0]  m_pend, m_mask, m_prev;
  logic        m_armed;
  logic [31:0] m_epc;
  logic [3:0]  m_id;
  int          m_level;
  logic [31:0] stk_epc[$];
  logic [3:0]  stk_id[$];

  vectored_intc dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .pc_next(pc_next), .ret(ret), .int_ack(int_ack), .vec_addr(vec_addr),
    .epc(epc), .irq_id(irq_id), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  function automatic int exp_take();
    int lim;
    if (reset || ret) return -1;
    if (m_level == 0) lim = 4;
    else if (NEST && m_level == 1) lim = int'(m_id);
    else return -1;
    for (int i = 0; i < lim; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_vec();
    int t;
    t = exp_take();
    return (t >= 0) ? 32'h1F0 + 32'(t) * 32'd4 : 32'd0;
  endfunction

  task automatic model_step();
    int t;
    logic [3:0] e;
    t = exp_take();
    if (reset) begin
      m_pend = '0; m_prev = '0; m_armed = 1'b0; m_epc = '0; m_id = '0; m_level = 0; m_mask = '1;
      stk_epc.delete(); stk_id.delete();
    end else begin
      e = m_armed ? (irq & ~m_prev) : 4'd0;
      m_prev = irq; m_armed = 1'b1;
      if (t >= 0) begin
        m_pend[t] = 1'b0;
        if (m_level == 1) begin stk_epc.push_back(m_epc); stk_id.push_back(m_id); end
        m_epc = pc_next; m_id = 4'(t); m_level++;
      end else if (ret && m_level > 0) begin
        if (m_level == 2) begin m_epc = stk_epc.pop_back(); m_id = stk_id.pop_back(); end
        m_level--;
      end
      m_pend |= e;
      if (mask_we) m_mask = mask_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic quiesce();
    irq = '0; mask_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ret = (m_level > 0);
      tick();
    end
    ret = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; irq = 4'b0001;
    tick(); tick();
    settle();
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b want=0", int_ack); end
    checks++; if (vec_addr !== 32'd0) begin errors++; $display("FAIL rst_vec got=%h want=0", vec_addr); end
    checks++; if (epc !== 32'd0) begin errors++; $display("FAIL rst_epc got=%h want=0", epc); end
    checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL rst_id got=%h want=0", irq_id); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc got=%b want=0", in_service); end
    reset = 1'b0;
    tick(); settle();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_noedge pending got=%b want=0000", pending); end
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL rst_noedge ack got=%b want=0", int_ack); end
    quiesce();
  endtask

  task automatic test_basic();
    irq = 4'b0010; pc_next = 32'h40;
    tick(); settle();
    checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL basic_ack got=%b want=1", int_ack); end
    checks++; if (vec_addr !== 32'h1F4) begin errors++; $display("FAIL basic_vec got=%h want=1f4", vec_addr); end
    tick(); settle();
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL basic_ack_once got=%b want=0", int_ack); end
    checks++; if (vec_addr !== 32'd0) begin errors++; $display("FAIL basic_vec_idle got=%h want=0", vec_addr); end
    checks++; if (epc !== 32'h40) begin errors++; $display("FAIL basic_epc got=%h want=40", epc); end
    checks++; if (irq_id !== 4'd1) begin errors++; $display("FAIL basic_id got=%h want=1", irq_id); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL basic_insvc got=%b want=1", in_service); end
    ret = 1'b1; tick(); ret = 1'b0; settle();
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL basic_ret got=%b want=0", in_service); end
    checks++; if (epc !== 32'h40) begin errors++; $display("FAIL basic_epc_hold got=%h want=40", epc); end
    quiesce();
  endtask

  task automatic test_priority();
    irq = 4'b1001; pc_next = 32'h100;
    tick(); settle();
    checks++; if (vec_addr !== 32'h1F0) begin errors++; $display("FAIL prio_first got=%h want=1f0", vec_addr); end
    tick(); settle();
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_pend got=%b want=1000", pending); end
    ret = 1'b1; settle();
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL prio_ret_noack got=%b want=0", int_ack); end
    tick(); ret = 1'b0; settle();
    checks++; if (vec_addr !== 32'h1FC) begin errors++; $display("FAIL prio_second got=%h want=1fc", vec_addr); end
    tick(); settle();
    checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL prio_id got=%h want=3", irq_id); end
    quiesce();
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_in = 4'b1011;
    tick(); mask_we = 1'b0;
    irq = 4'b0100;
    tick(); settle();
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL mask_block got=%b want=0", int_ack); end
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL mask_pend got=%b want=0100", pending); end
    tick();
    mask_we = 1'b1; mask_in = 4'b1111; settle();
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL mask_early got=%b want=0", int_ack); end
    tick(); mask_we = 1'b0; settle();
    checks++; if (vec_addr !== 32'h1F8) begin errors++; $display("FAIL mask_take got=%h want=1f8", vec_addr); end
    quiesce();
  endtask

  task automatic test_held();
    int takes;
    takes = 0;
    irq = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      ret = (m_level > 0);
      settle();
      if (int_ack === 1'b1) takes++;
      tick();
    end
    checks++; if (takes !== 1) begin errors++; $display("FAIL held_takes got=%0d want=1", takes); end
    quiesce();
  endtask

  task automatic test_reset_mid();
    irq = 4'b0001; pc_next = 32'h200;
    tick(); tick();
    irq = 4'b1001;
    tick(); settle();
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL rmid_pend got=%b want=1000", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL rmid_insvc got=%b want=1", in_service); end
    reset = 1'b1; settle();
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack got=%b want=0", int_ack); end
    tick(); settle();
    checks++; if ({int_ack, vec_addr, epc, irq_id, pending, in_service} !== 70'd0) begin
      errors++; $display("FAIL rmid_zero ack=%b vec=%h epc=%h id=%h pend=%b insvc=%b want all 0",
                         int_ack, vec_addr, epc, irq_id, pending, in_service); end
    reset = 1'b0;
    tick(); settle();
    checks++; if (pending !== 4'b0000 || int_ack !== 1'b0) begin
      errors++; $display("FAIL rmid_release pend=%b ack=%b want 0000/0", pending, int_ack); end
    quiesce();
  endtask

  task automatic test_nest();
    irq = 4'b0100; pc_next = 32'h80;
    tick(); tick(); settle();
    checks++; if (epc !== 32'h80 || irq_id !== 4'd2) begin
      errors++; $display("FAIL nest_outer epc=%h id=%h want 80/2", epc, irq_id); end
    irq = 4'b0101; pc_next = 32'h9C;
    tick(); settle();
    if (NEST) begin
      checks++; if (vec_addr !== 32'h1F0) begin errors++; $display("FAIL nest_pre got=%h want=1f0", vec_addr); end
      tick(); settle();
      checks++; if (epc !== 32'h9C || irq_id !== 4'd0) begin
        errors++; $display("FAIL nest_inner epc=%h id=%h want 9c/0", epc, irq_id); end
      ret = 1'b1; tick(); ret = 1'b0; settle();
      checks++; if (epc !== 32'h80 || irq_id !== 4'd2 || in_service !== 1'b1) begin
        errors++; $display("FAIL nest_pop epc=%h id=%h insvc=%b want 80/2/1", epc, irq_id, in_service); end
    end else begin
      checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL nest_nopre got=%b want=0", int_ack); end
      ret = 1'b1; tick(); ret = 1'b0; settle();
      checks++; if (vec_addr !== 32'h1F0) begin errors++; $display("FAIL nest_after got=%h want=1f0", vec_addr); end
      tick(); settle();
      checks++; if (epc !== 32'h9C || irq_id !== 4'd0) begin
        errors++; $display("FAIL nest_after_ctx epc=%h id=%h want 9c/0", epc, irq_id); end
    end
    quiesce();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ 4'($urandom);
      ret     = (m_level > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mask_we = ($urandom_range(0, 11) == 0);
      mask_in = 4'($urandom);
      reset   = ($urandom_range(0, 79) == 0);
      pc_next = $urandom & 32'hFFFF_FFFC;
      settle();
      checks++; if (int_ack !== (exp_take() >= 0)) begin errors++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, int_ack, exp_take() >= 0); end
      checks++; if (vec_addr !== exp_vec()) begin errors++; $display("FAIL rnd_vec c=%0d got=%h want=%h", c, vec_addr, exp_vec()); end
      checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd_epc c=%0d got=%h want=%h", c, epc, m_epc); end
      checks++; if (irq_id !== m_id) begin errors++; $display("FAIL rnd_id c=%0d got=%h want=%h", c, irq_id, m_id); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pend c=%0d got=%b want=%b", c, pending, m_pend); end
      checks++; if (in_service !== (m_level != 0)) begin errors++; $display("FAIL rnd_insvc c=%0d got=%b want=%b", c, in_service, m_level != 0); end
      tick();
    end
    reset = 1'b0;
    quiesce();
  endtask

  initial begin
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0; pc_next = '0; ret = 1'b0;
    m_pend = '0; m_mask = '1; m_prev = '0; m_armed = 1'b0; m_epc = '0; m_id = '0; m_level = 0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_held();
    test_reset_mid();
    test_nest();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
